alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Requester for the 16-bit combinational ALU (a, b, alu_control -> result, zero).
//  Accepts operation requests over a valid/ready handshake and drives the ALU input ports.
//  Registers the ALU output and returns it over a valid/ready response channel.
//  Adds an iterative unsigned multiply built from repeated ALU ADDs, so the datapath
//  gains MUL without changing the ALU.
// PARAMETERS
//  WIDTH   16      operand/result width; must match the ALU width
//  MUL_OP  3'b010  req_op code handled locally as a multi-cycle multiply
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      reset, asynchronous, active-low
//  req_valid     in   1      request valid
//  req_ready     out  1      request ready; 1 only in IDLE while rst_n=1
//  req_op        in   3      000 ADD, 001 SUB, MUL_OP MUL, others forwarded to ALU
//  req_a/req_b   in   WIDTH  operands
//  rsp_valid     out  1      response valid
//  rsp_ready     in   1      response accepted
//  rsp_result    out  WIDTH  result
//  rsp_zero      out  1      1 when rsp_result==0
//  alu_a/alu_b   out  WIDTH  to ALU a/b
//  alu_control   out  3      to ALU alu_control
//  alu_result    in   WIDTH  from ALU result
//  alu_zero      in   1      from ALU zero
//  busy          out  1      1 when state!=IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; rsp_valid/rsp_result/rsp_zero/busy=0;
//    alu_a/alu_b/alu_control=0; req_ready=0 while rst_n=0; in-flight op discarded.
//  - FSM states: IDLE, EXEC, MUL, RESP. No overlap: one op in flight at a time.
//  - IDLE: ALU inputs driven 0/0/000. On edge E0 with req_valid&&req_ready:
//    latch op/a/b; go to MUL if op==MUL_OP, else go to EXEC.
//  - EXEC: alu_a=a, alu_b=b, alu_control=op (011..111 passed through unchanged).
//    Next edge: rsp_result<=alu_result, rsp_zero<=alu_zero; go to RESP.
//    rsp_valid rises after E1 (1-cycle latency).
//  - MUL: acc=0, mcand=a, mplier=b, cnt=0 at entry. Each cycle drive alu_a=acc,
//    alu_b=mcand, alu_control=000.
//    Each edge: if mplier[0], acc<=alu_result; mcand<<=1; mplier>>=1; cnt++.
//    Exactly WIDTH iterations; no early exit.
//    On edge E(WIDTH): rsp_result<=final acc, rsp_zero<=(final acc==0); go to RESP.
//    rsp_valid rises after E16 for WIDTH=16.
//  - Arithmetic: modulo 2^WIDTH, unsigned. ADD 0xFFFF+1 gives 0x0000 with zero=1.
//    SUB 0-1 gives 0xFFFF. MUL keeps the low WIDTH bits of the product.
//  - RESP: rsp_* held stable while rsp_ready=0; ALU inputs return to 0.
//    On rsp_valid&&rsp_ready: rsp_valid<=0 and go to IDLE. req_ready rises the next cycle.
//    rsp_result/rsp_zero keep their last value after the handshake.
//  - req_valid while busy: ignored (not accepted, no side effects). req_* sampled only at E0.
//  - Reset asserted in any state (incl. mid-MUL or RESP): immediate abort to reset values;
//    no response emitted for the aborted op.
// CONFIGURATION
//  ALU_SEQ_OVF_EN defined: extra output rsp_ovf (1 bit), reset 0, registered with rsp_result:
//    ADD: signed overflow, a[15]==b[15] && res[15]!=a[15]
//    SUB: signed overflow, a[15]!=b[15] && res[15]!=a[15]
//    MUL: 1 if full unsigned product >= 2^WIDTH
//    Forwarded ops: 0
//  ALU_SEQ_OVF_EN undefined: rsp_ovf port and all overflow logic absent; all else identical.
// TESTING
//  1 ADD a=0x7FFF b=0x0001 -> alu_control=000 in EXEC; rsp_result=0x8000, zero=0,
//    rsp_valid 1 edge after accept; rsp_ovf=1 if EN.
//  2 SUB 0x0005-0x0005 -> 0x0000 zero=1; SUB 0x0000-0x0001 -> 0xFFFF zero=0, ovf=0 if EN.
//  3 MUL 0x0012*0x0034 -> 0x03A8 after 16 edges, alu_control=000 throughout, busy=1;
//    MUL 0x0100*0x0100 -> 0x0000 zero=1, ovf=1 if EN.
//  4 rsp_ready=0 for 5 cycles after ADD 1+2 -> rsp_result=0x0003 stable, req_ready=0;
//    second req not accepted until the cycle after the rsp handshake.
//  5 rst_n pulsed low at MUL iteration 7 -> rsp_valid=0, busy=0, alu_* =0 immediately;
//    then ADD 2+3 -> 0x0005.
//  6 op=3'b101 a=4 b=6 -> alu_control=101 in EXEC; rsp_result=alu_result (0x000A with
//    current ALU default), ovf=0 if EN.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Request/response front end for a 16-bit combinational ALU.
//            It forwards single-cycle ops to the ALU and builds an unsigned
//            multiply out of WIDTH shift-and-add iterations through the ALU.
// Config   : define ALU_SEQ_OVF_EN to add the rsp_ovf output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int         WIDTH  = 16,
  parameter logic [2:0] MUL_OP = 3'b010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
`ifdef ALU_SEQ_OVF_EN
  ,output logic            rsp_ovf
`endif
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [2:0]       OP_ADD   = 3'b000;
  localparam logic [2:0]       OP_SUB   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  // a_q doubles as the shifting multiplicand and b_q as the shifting multiplier
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [WIDTH-1:0] acc_step;

`ifdef ALU_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
  // lost_q: a set bit of the multiplicand has been shifted out of the word
  logic             lost_q, lost_d;
  logic             mul_ovf_q, mul_ovf_d;
  logic [WIDTH:0]   mul_sum;
  assign mul_sum = {1'b0, acc_q} + {1'b0, a_q};
  assign rsp_ovf = ovf_q;
`endif

  assign req_ready  = (state_q == ST_IDLE) && rst_n;
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q        <= 1'b0;
      lost_q       <= 1'b0;
      mul_ovf_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q        <= ovf_d;
      lost_q       <= lost_d;
      mul_ovf_q    <= mul_ovf_d;
`endif
    end
  end

  // Next-state, datapath updates and ALU port drive
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    alu_a        = '0;
    alu_b        = '0;
    alu_control  = 3'b000;
    // accumulator after this iteration: add the multiplicand only on a 1 bit
    acc_step     = b_q[0] ? alu_result : acc_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_d        = ovf_q;
    lost_d       = lost_q;
    mul_ovf_d    = mul_ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (req_op == MUL_OP) ? ST_MUL : ST_EXEC;
`ifdef ALU_SEQ_OVF_EN
          lost_d    = 1'b0;
          mul_ovf_d = 1'b0;
`endif
        end
      end
      ST_EXEC: begin
        alu_a        = a_q;
        alu_b        = b_q;
        alu_control  = op_q;
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
`ifdef ALU_SEQ_OVF_EN
        if (op_q == OP_ADD)
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_result[WIDTH-1] != a_q[WIDTH-1]);
        else if (op_q == OP_SUB)
          ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_result[WIDTH-1] != a_q[WIDTH-1]);
        else
          ovf_d = 1'b0;
`endif
      end
      ST_MUL: begin
        alu_a       = acc_q;
        alu_b       = a_q;
        alu_control = OP_ADD;
        acc_d       = acc_step;
        a_d         = a_q << 1;
        b_d         = b_q >> 1;
        cnt_d       = cnt_q + 1'b1;
`ifdef ALU_SEQ_OVF_EN
        // product overflows if a used partial product lost bits or the sum carried
        mul_ovf_d = mul_ovf_q | (b_q[0] & (lost_q | mul_sum[WIDTH]));
        lost_d    = lost_q | a_q[WIDTH-1];
`endif
        if (cnt_q == CNT_LAST) begin
          rsp_result_d = acc_step;
          rsp_zero_d   = (acc_step == '0);
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
`ifdef ALU_SEQ_OVF_EN
          ovf_d        = mul_ovf_d;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Directed self-checking bench for alu_op_sequencer with a
//            behavioural ALU model. Define ALU_SEQ_OVF_EN to check rsp_ovf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  localparam int         W      = 16;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_control;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         busy;
`ifdef ALU_SEQ_OVF_EN
  logic         rsp_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.WIDTH(W), .MUL_OP(OP_MUL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
`ifdef ALU_SEQ_OVF_EN
    ,.rsp_ovf    (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU; unlisted codes add
  always_comb begin
    case (alu_control)
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a + alu_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Count edges after the accept edge until rsp_valid; watch alu_control/busy meanwhile
  task automatic wait_rsp(input logic [2:0] exp_ctl, output int lat, output logic ctl_ok);
    lat    = 0;
    ctl_ok = (alu_control == exp_ctl) && busy;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!rsp_valid) ctl_ok = ctl_ok && (alu_control == exp_ctl) && busy;
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_post_hs"}, {29'd0, rsp_valid, busy, req_ready}, 32'b001);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input logic exp_zero, input logic exp_ovf, input int exp_lat);
    int   lat;
    logic ctl_ok;
    issue(op, a, b);
    wait_rsp((op == OP_MUL) ? OP_ADD : op, lat, ctl_ok);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_alu_ctl"}, {31'd0, ctl_ok}, 32'd1);
    check({tag, "_result"}, {16'd0, rsp_result}, {16'd0, exp_res});
    check({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
`ifdef ALU_SEQ_OVF_EN
    check({tag, "_ovf"}, {31'd0, rsp_ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("note: undefined ovf expectation in %s", tag);
`endif
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    logic ctl_ok;
    logic stable;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #3;
    check("reset_outputs", {26'd0, rsp_valid, rsp_zero, busy, req_ready, 2'b00}, 32'd0);
    check("reset_alu", {alu_a, alu_b[12:0], alu_control}, 32'd0);
    check("reset_result", {16'd0, rsp_result}, 32'd0);
`ifdef ALU_SEQ_OVF_EN
    check("reset_ovf", {31'd0, rsp_ovf}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD / SUB corners
    run_op("add_7fff_1", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1);
    run_op("add_ffff_1", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1);
    run_op("sub_5_5",    OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1);
    run_op("sub_0_1",    OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1);

    // Multiply: 18*52=936, 256*256 wraps to 0, 0xFFFF^2 low word is 1
    run_op("mul_12_34",   OP_MUL, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 16);
    run_op("mul_100_100", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 16);
    run_op("mul_ffff_sq", OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16);

    // Forwarded op code reaches the ALU unchanged
    run_op("fwd_101", 3'b101, 16'h0004, 16'h0006, 16'h000A, 1'b0, 1'b0, 1);

    // Response back-pressure with a second request waiting
    issue(OP_ADD, 16'h0001, 16'h0002);
    wait_rsp(OP_ADD, lat, ctl_ok);
    check("stall_add_result", {16'd0, rsp_result}, 32'h0003);
    req_valid = 1'b1;
    req_op    = OP_SUB;
    req_a     = 16'h0009;
    req_b     = 16'h0004;
    stable    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stable = stable && rsp_valid && (rsp_result == 16'h0003) && !req_ready && busy;
    end
    check("stall_hold", {31'd0, stable}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stall_release", {29'd0, rsp_valid, busy, req_ready}, 32'b001);
    check("stall_result_kept", {16'd0, rsp_result}, 32'h0003);
    @(negedge clk);
    req_valid = 1'b0;
    check("second_accepted", {28'd0, busy, alu_control}, {28'd1, OP_SUB});
    wait_rsp(OP_SUB, lat, ctl_ok);
    check("second_latency", lat, 1);
    check("second_result", {16'd0, rsp_result}, 32'h0005);
    handshake("second");

    // Reset in the middle of a multiply
    issue(OP_MUL, 16'h0003, 16'h0005);
    repeat (7) @(negedge clk);
    check("mul_mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_status", {29'd0, rsp_valid, busy, req_ready}, 32'd0);
    check("abort_alu", {alu_a, alu_b[12:0], alu_control}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
    run_op("add_after_abort", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
